// File: rtl/dircc_counter_array.sv
// dircc_counter_array
//   CHANNELS independent up/down counters behind an Avalon-MM slave, used by
//   HPS software to exercise and time fabric logic during DiRCC bring-up.
//   Each channel has CTRL, COUNT, COMPARE and STATUS registers; a shared
//   prescaler paces all channels, and the sticky STATUS bits of every channel
//   with IRQ_EN set are combined into one registered interrupt.
//
// Ports
//   clk_clk            system clock
//   reset_reset        asynchronous, active-high reset (clears all state)
//   avs_address        word address: channel = address[MSB:2], register = address[1:0]
//   avs_read           read strobe (no waitrequest)
//   avs_write          write strobe, takes effect on the edge it is presented
//   avs_writedata      write data
//   avs_readdata       registered read data, valid with avs_readdatavalid
//   avs_readdatavalid  one-cycle pulse, the cycle after avs_read
//   irq                registered OR over channels of (STATUS & IRQ_EN)
//
// Register map per channel
//   0 CTRL    bit0 EN, bit1 DOWN, bit2 SAT (1 saturate / 0 wrap), bit3 IRQ_EN
//   1 COUNT   write loads the counter
//   2 COMPARE match value
//   3 STATUS  bit0 MATCH, bit1 OVF; sticky, write-1-to-clear
//
// Bus handshake: a read or write is accepted on every clock edge where its
// strobe is high; there is no back-pressure. A read samples register state
// before any same-edge write or count step and answers one cycle later.

module dircc_counter_array #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int PRESCALE    = 1
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset,
    input  logic [$clog2(CHANNELS)+1:0]     avs_address,
    input  logic                            avs_read,
    input  logic                            avs_write,
    input  logic [31:0]                     avs_writedata,
    output logic [31:0]                     avs_readdata,
    output logic                            avs_readdatavalid,
    output logic                            irq
);

    localparam int AW = $clog2(CHANNELS) + 2;
    localparam int CW = COUNT_WIDTH;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [AW-1:0]                w_chan;
    logic [1:0]                   w_reg;
    logic                         w_tick;
    logic [31:0]                  w_rd_val;
    logic                         w_irq;
    logic [CHANNELS-1:0][31:0]    w_ch_rd;
    logic [CHANNELS-1:0]          w_ch_irq;

    logic [PW-1:0]                r_pre;
    logic [31:0]                  r_readdata;
    logic                         r_rdv;
    logic                         r_irq;

    // Shift rather than slice so CHANNELS=1 (no channel bits) still works.
    assign w_chan = avs_address >> 2;
    assign w_reg  = avs_address[1:0];

    // Prescaler runs continuously; with PRESCALE=1 it sits at 0 and ticks every cycle.
    assign w_tick = (r_pre == PW'(PRESCALE - 1));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [3:0]    r_ctrl;
        logic [CW-1:0] r_count;
        logic [CW-1:0] r_cmp;
        logic [1:0]    r_status;

        logic          w_sel;
        logic          w_wr_ctrl;
        logic          w_wr_count;
        logic          w_wr_cmp;
        logic          w_wr_status;
        logic          w_at_lim;
        logic          w_step;
        logic [CW-1:0] w_next;
        logic [1:0]    w_set;
        logic [1:0]    w_status_n;

        assign w_sel       = (w_chan == AW'(c));
        assign w_wr_ctrl   = avs_write && w_sel && (w_reg == 2'd0);
        assign w_wr_count  = avs_write && w_sel && (w_reg == 2'd1);
        assign w_wr_cmp    = avs_write && w_sel && (w_reg == 2'd2);
        assign w_wr_status = avs_write && w_sel && (w_reg == 2'd3);

        always_comb begin
            w_at_lim   = r_ctrl[1] ? (r_count == '0) : (r_count == '1);
            w_next     = r_ctrl[1] ? (r_count - CW'(1)) : (r_count + CW'(1));
            if (w_at_lim) begin
                // Saturate holds the boundary value; wrap jumps to the other end.
                w_next = r_ctrl[2] ? r_count : (r_ctrl[1] ? '1 : '0);
            end
            // A COUNT load on a tick suppresses that tick's step entirely.
            w_step     = w_tick && r_ctrl[0] && !w_wr_count;
            w_set      = {w_step && w_at_lim, w_step && (w_next == r_cmp)};
            w_status_n = w_wr_status ? (r_status & ~avs_writedata[1:0]) : r_status;
            // New events win over a same-cycle clear.
            w_status_n = w_status_n | w_set;
        end

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                r_ctrl   <= '0;
                r_count  <= '0;
                r_cmp    <= '0;
                r_status <= '0;
            end else begin
                if (w_wr_ctrl) r_ctrl <= avs_writedata[3:0];
                if (w_wr_count) r_count <= avs_writedata[CW-1:0];
                else if (w_step) r_count <= w_next;
                if (w_wr_cmp) r_cmp <= avs_writedata[CW-1:0];
                r_status <= w_status_n;
            end
        end

        always_comb begin
            case (w_reg)
                2'd0:    w_ch_rd[c] = {28'd0, r_ctrl};
                2'd1:    w_ch_rd[c] = 32'(r_count);
                2'd2:    w_ch_rd[c] = 32'(r_cmp);
                default: w_ch_rd[c] = {30'd0, r_status};
            endcase
        end

        assign w_ch_irq[c] = r_ctrl[3] && (|r_status);
    end

    // Channels at or beyond CHANNELS match no entry and read as zero.
    always_comb begin
        w_rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_chan == AW'(c)) w_rd_val = w_ch_rd[c];
        end
    end

    assign w_irq = |w_ch_irq;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_pre      <= '0;
            r_readdata <= '0;
            r_rdv      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : (r_pre + PW'(1));
            r_rdv <= avs_read;
            if (avs_read) r_readdata <= w_rd_val;
            r_irq <= w_irq;
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_rdv;
    assign irq               = r_irq;

endmodule

// File: tb/tb_dircc_counter_array.sv
// tb_dircc_counter_array
//   Three instances share one bus: A (4 ch, 32 bit, prescale 1),
//   B (3 ch, 8 bit, prescale 1; channel 3 is out of range) and
//   C (4 ch, 32 bit, prescale 4). A behavioural model of the register map
//   predicts readdata / readdatavalid / irq every cycle; directed steps add
//   fixed expectations taken from the intended behaviour.

module tb_dircc_counter_array;

    localparam int P_CH [3] = '{4, 3, 4};
    localparam int P_CW [3] = '{32, 8, 32};
    localparam int P_PS [3] = '{1, 1, 4};

    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [3:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] rd_v [3];
    logic        rdv_v [3];
    logic        irq_v [3];

    int n_checks = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    longint      m_count [3][4];
    longint      m_cmp   [3][4];
    int          m_ctrl  [3][4];
    int          m_status[3][4];
    int          m_pre   [3];
    logic [31:0] exp_rd  [3];
    logic        exp_rdv [3];
    logic        exp_irq [3];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dircc_counter_array #(.CHANNELS(4), .COUNT_WIDTH(32), .PRESCALE(1)) u_dut_a (
        .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd_v[0]), .avs_readdatavalid(rdv_v[0]), .irq(irq_v[0]));

    dircc_counter_array #(.CHANNELS(3), .COUNT_WIDTH(8), .PRESCALE(1)) u_dut_b (
        .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd_v[1]), .avs_readdatavalid(rdv_v[1]), .irq(irq_v[1]));

    dircc_counter_array #(.CHANNELS(4), .COUNT_WIDTH(32), .PRESCALE(4)) u_dut_c (
        .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd_v[2]), .avs_readdatavalid(rdv_v[2]), .irq(irq_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input int d, input int c, input int rg);
        case (rg)
            0:       return 32'(m_ctrl[d][c]);
            1:       return 32'(m_count[d][c]);
            2:       return 32'(m_cmp[d][c]);
            default: return 32'(m_status[d][c]);
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_count[d][c] = 0; m_cmp[d][c] = 0; m_ctrl[d][c] = 0; m_status[d][c] = 0;
            end
            m_pre[d] = 0; exp_rd[d] = '0; exp_rdv[d] = 1'b0; exp_irq[d] = 1'b0;
        end
    endtask

    // One clock edge of behaviour, from the register-map rules.
    task automatic model_update();
        int ch, rg, set;
        longint mx, nx;
        logic tick, wr;
        ch = int'(avs_address) >> 2;
        rg = int'(avs_address) & 3;
        for (int d = 0; d < 3; d++) begin
            mx = (longint'(1) << P_CW[d]) - 1;
            exp_rdv[d] = avs_read;
            if (avs_read) exp_rd[d] = (ch < P_CH[d]) ? reg_value(d, ch, rg) : 32'h0;
            exp_irq[d] = 1'b0;
            for (int c = 0; c < P_CH[d]; c++)
                if (m_ctrl[d][c][3] && m_status[d][c] != 0) exp_irq[d] = 1'b1;
            tick = (m_pre[d] == P_PS[d] - 1);
            m_pre[d] = (m_pre[d] + 1) % P_PS[d];
            for (int c = 0; c < P_CH[d]; c++) begin
                wr = avs_write && (ch == c);
                set = 0;
                if (wr && rg == 1) begin
                    m_count[d][c] = longint'(avs_writedata) & mx;
                end else if (tick && m_ctrl[d][c][0]) begin
                    nx = m_ctrl[d][c][1] ? m_count[d][c] - 1 : m_count[d][c] + 1;
                    if (nx < 0 || nx > mx) begin
                        set = set | 2;
                        if (m_ctrl[d][c][2]) nx = m_count[d][c];
                        else nx = (nx < 0) ? mx : 0;
                    end
                    if (nx == m_cmp[d][c]) set = set | 1;
                    m_count[d][c] = nx;
                end
                if (wr && rg == 3) m_status[d][c] = m_status[d][c] & ~int'(avs_writedata[1:0]);
                m_status[d][c] = m_status[d][c] | set;
                if (wr && rg == 0) m_ctrl[d][c] = int'(avs_writedata[3:0]);
                if (wr && rg == 2) m_cmp[d][c] = longint'(avs_writedata) & mx;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick_clk();
        @(posedge clk);
        if (reset_reset) model_reset(); else model_update();
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d rdv", d), {31'd0, rdv_v[d]}, {31'd0, exp_rdv[d]});
            check($sformatf("dut%0d irq", d), {31'd0, irq_v[d]}, {31'd0, exp_irq[d]});
            if (exp_rdv[d]) check($sformatf("dut%0d readdata", d), rd_v[d], exp_rd[d]);
        end
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        avs_address = 4'(addr); avs_writedata = data; avs_write = 1'b1;
        tick_clk();
        avs_write = 1'b0;
    endtask

    task automatic do_read(input int addr);
        avs_address = 4'(addr); avs_read = 1'b1;
        tick_clk();
        avs_read = 1'b0;
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'hFFFF_FFFE;
            3:       return 32'h0000_00FE;
            4:       return 32'(int'($urandom_range(0, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] first, last;
        model_reset();

        // Reset state
        #3;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset dut%0d readdata", d), rd_v[d], 32'h0);
            check($sformatf("reset dut%0d rdv", d), {31'd0, rdv_v[d]}, 32'h0);
            check($sformatf("reset dut%0d irq", d), {31'd0, irq_v[d]}, 32'h0);
        end
        #9 reset_reset = 1'b0;

        // Every register reads 0 after reset; idle gap checks single-cycle rdv
        for (int a = 0; a < 16; a++) begin
            do_read(a);
            for (int d = 0; d < 3; d++) check($sformatf("post-reset read dut%0d a%0d", d, a), rd_v[d], 32'h0);
            tick_clk();
        end

        // Ch0 wrap at 32-bit max on A
        do_write(2, 32'h1234_5678);
        do_write(0, 32'h1);
        do_write(1, 32'hFFFF_FFFE);
        do_read(1);
        do_read(1);
        check("ch0 count max", rd_v[0], 32'hFFFF_FFFF);
        do_read(1);
        check("ch0 count wrapped", rd_v[0], 32'h0);
        do_write(0, 32'h0);
        do_read(3);
        check("ch0 status ovf", rd_v[0], 32'h2);
        do_write(3, 32'h2);
        do_read(3);
        check("ch0 status cleared", rd_v[0], 32'h0);

        // Ch1 down/saturate on B (8 bit)
        do_write(6, 32'h80);
        do_write(5, 32'h2);
        do_write(4, 32'h7);
        do_read(5); check("ch1 count 2", rd_v[1], 32'h2);
        do_read(5); check("ch1 count 1", rd_v[1], 32'h1);
        do_read(7); check("ch1 status before hold", rd_v[1], 32'h0);
        do_read(7); check("ch1 status ovf on hold", rd_v[1], 32'h2);
        do_read(5); check("ch1 count held 0", rd_v[1], 32'h0);
        do_read(5); check("ch1 count still 0", rd_v[1], 32'h0);
        do_write(4, 32'h0);

        // Ch2 compare match and irq on A
        do_write(10, 32'h5);
        do_write(8, 32'h9);
        repeat (5) tick_clk();
        check("ch2 irq before", {31'd0, irq_v[0]}, 32'h0);
        tick_clk();
        check("ch2 irq raised", {31'd0, irq_v[0]}, 32'h1);
        do_write(8, 32'h8);
        do_write(11, 32'h1);
        tick_clk();
        check("ch2 irq dropped", {31'd0, irq_v[0]}, 32'h0);
        do_write(9, 32'h5);
        do_read(11);
        check("ch2 load no match", rd_v[0], 32'h0);
        check("ch2 irq after load", {31'd0, irq_v[0]}, 32'h0);

        // Ch3 prescale 4 on C
        do_write(12, 32'h1);
        first = '0; last = '0;
        for (int i = 0; i < 9; i++) begin
            do_read(13);
            if (i == 0) first = rd_v[2];
            last = rd_v[2];
        end
        check("ch3 two ticks in 8 clocks", last - first, 32'h2);
        for (int i = 0; i < 8 && m_pre[2] != 3; i++) tick_clk();
        do_write(13, 32'd100);
        do_read(13);
        check("ch3 load wins over tick", rd_v[2], 32'd100);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_read(int'($urandom_range(0, 15)));
                4, 5, 6, 7: begin
                    int a;
                    a = int'($urandom_range(0, 15));
                    if ((a & 3) == 0) do_write(a, 32'(int'($urandom_range(0, 15))));
                    else if ((a & 3) == 3) do_write(a, 32'(int'($urandom_range(0, 3))));
                    else do_write(a, pick_data());
                end
                default: tick_clk();
            endcase
        end
        for (int a = 0; a < 16; a++) do_read(a);

        // Reset mid-count with a read response in flight
        do_write(0, 32'h1);
        do_write(12, 32'h1);
        repeat (3) tick_clk();
        avs_address = 4'd1; avs_read = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        avs_read = 1'b0;
        for (int d = 0; d < 3; d++) check($sformatf("inflight dut%0d rdv", d), {31'd0, rdv_v[d]}, 32'h1);
        #1 reset_reset = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async reset dut%0d rdv", d), {31'd0, rdv_v[d]}, 32'h0);
            check($sformatf("async reset dut%0d readdata", d), rd_v[d], 32'h0);
            check($sformatf("async reset dut%0d irq", d), {31'd0, irq_v[d]}, 32'h0);
        end
        tick_clk();
        reset_reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            do_read(a);
            for (int d = 0; d < 3; d++) check($sformatf("after reset dut%0d a%0d", d, a), rd_v[d], 32'h0);
        end
        repeat (8) tick_clk();
        do_read(1);
        for (int d = 0; d < 3; d++) check($sformatf("stopped dut%0d ch0", d), rd_v[d], 32'h0);
        do_read(13);
        check("stopped dut2 ch3", rd_v[2], 32'h0);
        tick_clk();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
